// File: rtl/spi_control_pkg.sv
// Shared types and constants for the spi_control byte serializer.
package spi_control_pkg;
  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_ACK} state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int FIELD_W        = 5;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  // Byte idx counted from the MSB end: idx 0 -> bits 31:24.
  function automatic logic [7:0] byte_sel(input logic [WORD_W-1:0] w,
                                          input logic [IDX_W-1:0]  idx);
    logic [WORD_W-1:0] s;
    s = w << (8 * idx);
    return s[WORD_W-1 -: 8];
  endfunction
endpackage

// File: rtl/spi_control_fifo.sv
// First-word-fall-through word FIFO with full/empty flags.
// A push while full is accepted when a pop happens in the same cycle.
module spi_control_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rp];

  always_ff @(posedge i_clock)
    if (w_push) r_mem[r_wp] <= i_data;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/spi_control.sv
// Serializes 32-bit words MSB-first into bytes paced by nextField changes.
// Define SPI_CONTROL_FIFO_EN to put a FIFO_DEPTH-word FIFO in front.
import spi_control_pkg::*;

module spi_control #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [WORD_W-1:0]  i_data,
  input  logic               i_dataReady,
  input  logic [FIELD_W-1:0] i_nextField,
  output logic               o_send,
  output logic [7:0]         o_byte
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  state_e             r_state, w_next;
  logic [WORD_W-1:0]  r_word, w_word;
  logic [IDX_W-1:0]   r_idx;
  logic [FIELD_W-1:0] r_snap;
  logic               r_send;
  logic [7:0]         r_byte;
  logic               w_avail_idle, w_avail_wait, w_load, w_adv;

`ifdef SPI_CONTROL_FIFO_EN
  logic w_empty, w_full;

  spi_control_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (i_dataReady),
    .i_data  (i_data),
    .i_pop   (w_load),
    .o_data  (w_word),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_avail_idle = !w_empty;
  assign w_avail_wait = !w_empty;
`else
  // Without a FIFO only IDLE listens to dataReady; the in-flight word is safe.
  assign w_word       = i_data;
  assign w_avail_idle = i_dataReady;
  assign w_avail_wait = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      IDLE: if (w_avail_idle) begin
        w_load = 1'b1;
        w_next = PRESENT;
      end
      PRESENT: w_next = WAIT_ACK;
      WAIT_ACK: if (i_nextField != r_snap) begin
        if (r_idx != LAST_IDX) begin
          w_adv  = 1'b1;
          w_next = PRESENT;
        end else if (w_avail_wait) begin
          w_load = 1'b1;
          w_next = PRESENT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_send  <= 1'b0;
      r_byte  <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_word <= w_word;
        r_idx  <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 1'b1;
      end
      // Freezing the snapshot only in WAIT_ACK absorbs changes seen while presenting.
      if (r_state != WAIT_ACK) r_snap <= i_nextField;
      r_send <= (r_state == PRESENT);
      if (r_state == PRESENT) r_byte <= byte_sel(r_word, r_idx);
    end
  end

  assign o_send = r_send;
  assign o_byte = r_byte;
endmodule

// File: tb/tb_spi_control.sv
// Self-checking bench for spi_control: vector table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_spi_control;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        dr = 1'b0;
  logic [4:0]  nf = '0;
  logic        send;
  logic [7:0]  obyte;

  int n_chk = 0;
  int n_fail = 0;

  spi_control #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_data      (data),
    .i_dataReady (dr),
    .i_nextField (nf),
    .o_send      (send),
    .o_byte      (obyte)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  typedef struct {
    logic        dr;
    logic [31:0] d;
    logic        inc;
    logic        es;
    logic [7:0]  eb;
  } vec_t;
  vec_t vq[$];

  // reference model state for the random phase
  logic [7:0] exp_q[$];
  logic [7:0] last_b;
  int         outstanding = 0;
  int         acked = 0;
  bit         ack_pend = 0;
  int         ack_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic d_r, input logic [31:0] d, input logic inc,
                     input logic es, input logic [7:0] eb);
    vec_t v;
    v.dr = d_r; v.d = d; v.inc = inc; v.es = es; v.eb = eb;
    vq.push_back(v);
  endtask

  // Pulse dataReady for one cycle, then wait (bounded) for the first send.
  task automatic send_word(input logic [31:0] w, input logic [7:0] exp_b, input string name);
    bit got;
    dr = 1'b1; data = w;
    tick();
    dr = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (send) got = 1;
    end
    chk({name, "_send"}, 32'(got), 32'd1);
    chk({name, "_byte"}, 32'(obyte), 32'(exp_b));
  endtask

  task automatic ack_expect(input logic [7:0] exp_b, input string name);
    bit got;
    nf = nf + 1'b1;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (send) got = 1;
    end
    chk({name, "_send"}, 32'(got), 32'd1);
    chk({name, "_byte"}, 32'(obyte), 32'(exp_b));
  endtask

  task automatic quiet(input int n, input logic [7:0] exp_b, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({name, "_nosend"}, 32'(send), 32'd0);
      chk({name, "_hold"}, 32'(obyte), 32'(exp_b));
    end
  endtask

  // One random cycle: a well-behaved SPI side acks each presented byte once.
  task automatic rand_cycle(input bit allow_dr);
    logic [31:0] w;
    bit do_dr, do_ack;
    do_dr = 0; do_ack = 0;
    w = $urandom;
`ifdef SPI_CONTROL_FIFO_EN
    if (allow_dr && outstanding < DEPTH && $urandom_range(0, 3) == 0) do_dr = 1;
`else
    if (allow_dr && $urandom_range(0, 5) == 0) do_dr = 1;
`endif
    if (ack_pend) begin
      if (ack_wait == 0) begin do_ack = 1; ack_pend = 0; end
      else ack_wait--;
    end
`ifdef SPI_CONTROL_FIFO_EN
    if (do_dr) begin
`else
    if (do_dr && outstanding == 0) begin
`endif
      for (int k = 0; k < 4; k++) exp_q.push_back(w[31-8*k -: 8]);
      outstanding++;
    end
    if (do_ack) begin
      acked++;
      if (acked % 4 == 0) outstanding--;
    end
    dr = do_dr; data = w;
    if (do_ack) nf = nf + 1'b1;
    tick();
    if (send) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_send", 32'(send), 32'd0);
      end else begin
        last_b = exp_q.pop_front();
        chk("rnd_byte", 32'(obyte), 32'(last_b));
      end
      ack_pend = 1;
      ack_wait = $urandom_range(0, 3);
    end else begin
      chk("rnd_hold", 32'(obyte), 32'(last_b));
    end
  endtask

  initial begin
    // reset
    nf = 5'd7;
    repeat (3) tick();
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_byte", 32'(obyte), 32'h00);
    rst_n = 1'b1;
    quiet(5, 8'h00, "rel_nf7");
    nf = 5'd9;
    quiet(3, 8'h00, "idle_nf_change");

    // vector table: DEADBEEF with nextField wrapping 31->0 on the second ack
    nf = 5'd30;
    tick();
    add(1, 32'hDEADBEEF, 0, 0, 8'h00);
`ifdef SPI_CONTROL_FIFO_EN
    add(0, 32'h0, 0, 0, 8'h00);
`endif
    add(0, 32'h0, 0, 1, 8'hDE);
    add(0, 32'h0, 1, 0, 8'hDE);
    add(0, 32'h0, 0, 1, 8'hAD);
    add(0, 32'h0, 1, 0, 8'hAD);
    add(0, 32'h0, 0, 1, 8'hBE);
    add(0, 32'h0, 1, 0, 8'hBE);
    add(0, 32'h0, 0, 1, 8'hEF);
    add(0, 32'h0, 1, 0, 8'hEF);
    add(0, 32'h0, 0, 0, 8'hEF);
    add(0, 32'h0, 1, 0, 8'hEF);
    add(0, 32'h0, 0, 0, 8'hEF);
    foreach (vq[i]) begin
      dr = vq[i].dr; data = vq[i].d;
      if (vq[i].inc) nf = nf + 1'b1;
      tick();
      chk($sformatf("vec%0d_send", i), 32'(send), 32'(vq[i].es));
      chk($sformatf("vec%0d_byte", i), 32'(obyte), 32'(vq[i].eb));
    end
    dr = 1'b0;

    // no ack for 100 cycles
    send_word(32'h12345678, 8'h12, "noack_first");
    quiet(100, 8'h12, "noack");
    ack_expect(8'h34, "noack_b1");
    ack_expect(8'h56, "noack_b2");
    ack_expect(8'h78, "noack_b3");
    nf = nf + 1'b1;
    quiet(3, 8'h78, "noack_done");

`ifdef SPI_CONTROL_FIFO_EN
    // back-to-back pushes
    begin
      int sends;
      dr = 1'b1; data = 32'h01020304; tick();
      data = 32'hA0B0C0D0; tick();
      dr = 1'b0;
      sends = 0;
      for (int i = 0; i < 6 && sends == 0; i++) begin
        tick();
        if (send) sends++;
      end
      chk("b2b_first", 32'(obyte), 32'h01);
      for (int k = 1; k < 8; k++) begin
        logic [63:0] pair;
        bit got;
        pair = 64'h01020304A0B0C0D0;
        nf = nf + 1'b1;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
          tick();
          if (send) begin got = 1; sends++; end
        end
        chk($sformatf("b2b_byte%0d", k), 32'(obyte), 32'(pair[63-8*k -: 8]));
      end
      nf = nf + 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (send) sends++;
      end
      chk("b2b_send_count", 32'(sends), 32'd8);
    end
`else
    // dataReady during WAIT_ACK is dropped
    send_word(32'h55667788, 8'h55, "drop_first");
    dr = 1'b1; data = 32'h11111111; tick();
    dr = 1'b0;
    chk("drop_pulse_nosend", 32'(send), 32'd0);
    ack_expect(8'h66, "drop_b1");
    ack_expect(8'h77, "drop_b2");
    ack_expect(8'h88, "drop_b3");
    nf = nf + 1'b1;
    quiet(6, 8'h88, "drop_done");
`endif

    // mid-word reset
    send_word(32'h99AABBCC, 8'h99, "mrst_first");
    ack_expect(8'hAA, "mrst_b1");
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_send", 32'(send), 32'd0);
    chk("mrst_byte", 32'(obyte), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    nf = nf + 1'b1;
    quiet(10, 8'h00, "mrst_resume");
    send_word(32'hCAFEF00D, 8'hCA, "cafe_first");
    ack_expect(8'hFE, "cafe_b1");
    ack_expect(8'hF0, "cafe_b2");
    ack_expect(8'h0D, "cafe_b3");
    nf = nf + 1'b1;
    quiet(2, 8'h0D, "cafe_done");

    // random traffic against the queue model
    last_b = 8'h0D;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 400 && (outstanding > 0 || ack_pend); i++) rand_cycle(1'b0);
    chk("rnd_drained", 32'(outstanding), 32'd0);
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
